// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word, flags unencodable
// bundles (emitted as NOP with err set) and queues results in a small valid/ready FIFO.
module inst_encoder #(
   parameter int XLEN       = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_itype,
   input  logic [6:0]       in_opcode,
   input  logic [4:0]       in_rd,
   input  logic [4:0]       in_rs1,
   input  logic [4:0]       in_rs2,
   input  logic [2:0]       in_funct3,
   input  logic [6:0]       in_funct7,
   input  logic [XLEN-1:0]  in_imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_inst,
   output logic             out_err,
   output logic [CNT_W-1:0] enc_count,
   output logic [CNT_W-1:0] err_count
);

   localparam logic [2:0] TYPE_R = 3'd0;
   localparam logic [2:0] TYPE_I = 3'd1;
   localparam logic [2:0] TYPE_S = 3'd2;
   localparam logic [2:0] TYPE_B = 3'd3;
   localparam logic [2:0] TYPE_U = 3'd4;
   localparam logic [2:0] TYPE_J = 3'd5;
   localparam logic [2:0] TYPE_NONE = 3'd7;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [31:0] NOP_INST  = 32'h0000_0013;

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]      PTR_ONE = (AW+1)'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Decoder's opcode-to-type table; unknown opcodes map to TYPE_NONE.
   function automatic logic [2:0] opc_type(input logic [6:0] op);
      logic [2:0] t;
      case (op)
         7'b0110011: t = TYPE_R;
         7'b0010011, 7'b0000011, 7'b1100111,
         7'b0001111, 7'b1110011: t = TYPE_I;
         7'b0100011: t = TYPE_S;
         7'b1100011: t = TYPE_B;
         7'b0110111, 7'b0010111: t = TYPE_U;
         7'b1101111: t = TYPE_J;
         default:    t = TYPE_NONE;
      endcase
      return t;
   endfunction

   // True when v[XLEN-1:lsb] are all copies of the sign bit.
   function automatic logic sext_fits(input logic [XLEN-1:0] v, input int lsb);
      logic ok;
      ok = 1'b1;
      for (int k = 0; k < XLEN; k++) begin
         if (k >= lsb && v[k] != v[XLEN-1]) begin
            ok = 1'b0;
         end else begin
            ok = ok;
         end
      end
      return ok;
   endfunction

   logic [31:0] raw_s;
   logic        imm_err_s;
   logic        type_err_s;
   logic        enc_err_s;
   logic [31:0] enc_inst_s;
   logic        is_shift_s;

   // Field packing and immediate range checks.
   always_comb begin
      raw_s      = NOP_INST;
      imm_err_s  = 1'b0;
      is_shift_s = (in_opcode == OPC_OP_IMM) && (in_funct3[1:0] == 2'b01);
      case (in_itype)
         TYPE_R: raw_s = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
         TYPE_I: begin
            if (is_shift_s) begin
               raw_s     = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
               imm_err_s = (in_imm[XLEN-1:5] != '0);
            end else begin
               raw_s     = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
               imm_err_s = !sext_fits(in_imm, 11);
            end
         end
         TYPE_S: begin
            raw_s     = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            imm_err_s = !sext_fits(in_imm, 11);
         end
         TYPE_B: begin
            raw_s     = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                         in_imm[4:1], in_imm[11], in_opcode};
            imm_err_s = !sext_fits(in_imm, 12) || in_imm[0];
         end
         TYPE_U: begin
            raw_s     = {in_imm[31:12], in_rd, in_opcode};
            imm_err_s = (in_imm[11:0] != 12'h000);
         end
         TYPE_J: begin
            raw_s     = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
            imm_err_s = !sext_fits(in_imm, 20) || in_imm[0];
         end
         default: begin
            raw_s     = NOP_INST;
            imm_err_s = 1'b1;
         end
      endcase
      type_err_s = (opc_type(in_opcode) != in_itype);
      enc_err_s  = imm_err_s || type_err_s;
      enc_inst_s = enc_err_s ? NOP_INST : raw_s;
   end

   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   logic [31:0]  mem_inst_q [FIFO_DEPTH];
   logic         mem_err_q  [FIFO_DEPTH];
   logic         ready_q;
   logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic         empty_s, full_s, push_s, pop_s;

   assign empty_s   = (wr_ptr_q == rd_ptr_q);
   assign full_s    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign in_ready  = ready_q && !full_s;
   assign out_valid = !empty_s;
   assign out_inst  = empty_s ? 32'h0000_0000 : mem_inst_q[rd_ptr_q[AW-1:0]];
   assign out_err   = empty_s ? 1'b0 : mem_err_q[rd_ptr_q[AW-1:0]];
   assign enc_count = enc_cnt_q;
   assign err_count = err_cnt_q;
   assign push_s    = in_valid && in_ready;
   assign pop_s     = out_valid && out_ready;

   // Pointer and saturating counter next-state.
   always_comb begin
      wr_ptr_d  = push_s ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d  = pop_s  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      enc_cnt_d = enc_cnt_q;
      err_cnt_d = err_cnt_q;
      if (push_s && enc_err_s && err_cnt_q != CNT_MAX) begin
         err_cnt_d = err_cnt_q + CNT_ONE;
      end else if (push_s && !enc_err_s && enc_cnt_q != CNT_MAX) begin
         enc_cnt_d = enc_cnt_q + CNT_ONE;
      end else begin
         enc_cnt_d = enc_cnt_q;
      end
   end

   // FIFO storage, pointers, counters and post-reset ready.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         ready_q   <= 1'b0;
         enc_cnt_q <= '0;
         err_cnt_q <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_inst_q[i] <= 32'h0000_0000;
            mem_err_q[i]  <= 1'b0;
         end
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         ready_q   <= 1'b1;
         enc_cnt_q <= enc_cnt_d;
         err_cnt_q <= err_cnt_d;
         if (push_s) begin
            mem_inst_q[wr_ptr_q[AW-1:0]] <= enc_inst_s;
            mem_err_q[wr_ptr_q[AW-1:0]]  <= enc_err_s;
         end
      end
   end

endmodule
